// File: rtl/parallel_port_ctrl.sv
// Avalon-MM bidirectional parallel port: DIR/PIN/PORT/SET/CLR registers.
// Define PARALLEL_PORT_CTRL_IRQ_EN to build MASK/EDGE capture and irq.
module parallel_port_ctrl #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       avs_address,
  input  logic             avs_chipselect,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [3:0]       avs_byteenable,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq,
  inout  wire  [WIDTH-1:0] pport
);

  localparam logic [2:0] A_DIR  = 3'd0;
  localparam logic [2:0] A_PIN  = 3'd1;
  localparam logic [2:0] A_PORT = 3'd2;
  localparam logic [2:0] A_SET  = 3'd3;
  localparam logic [2:0] A_CLR  = 3'd4;
  localparam logic [2:0] A_MASK = 3'd5;
  localparam logic [2:0] A_EDGE = 3'd6;

  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_port;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [31:0]      r_readdata;

  logic [31:0]      w_be32;
  logic [WIDTH-1:0] w_be;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_bits;
  logic [WIDTH-1:0] w_pin;
  logic [WIDTH-1:0] w_port_nxt;
  logic [31:0]      w_mask32;
  logic [31:0]      w_edge32;
  logic [31:0]      w_rdata;
  logic             w_wr;
  logic             w_rd;
  logic             w_wr_dir;
  logic             w_wr_port;
  logic             w_wr_set;
  logic             w_wr_clr;

  assign w_be32 = {{8{avs_byteenable[3]}},
                   {8{avs_byteenable[2]}},
                   {8{avs_byteenable[1]}},
                   {8{avs_byteenable[0]}}};
  assign w_be    = w_be32[WIDTH-1:0];
  assign w_wdata = avs_writedata[WIDTH-1:0];
  // disabled lanes behave as zero data
  assign w_bits  = w_wdata & w_be;

  assign w_wr = avs_chipselect & avs_write;
  assign w_rd = avs_chipselect & avs_read;

  assign w_wr_dir  = w_wr && (avs_address == A_DIR);
  assign w_wr_port = w_wr && (avs_address == A_PORT);
  assign w_wr_set  = w_wr && (avs_address == A_SET);
  assign w_wr_clr  = w_wr && (avs_address == A_CLR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dir <= '0;
    end else if (w_wr_dir) begin
      r_dir <= (r_dir & ~w_be) | (w_wdata & w_be);
    end
  end

  always_comb begin
    w_port_nxt = r_port;
    unique case (1'b1)
      w_wr_port: w_port_nxt = (r_port & ~w_be) | (w_wdata & w_be);
      w_wr_set:  w_port_nxt = r_port | w_bits;
      w_wr_clr:  w_port_nxt = r_port & ~w_bits;
      default:   w_port_nxt = r_port;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_port <= '0;
    end else begin
      r_port <= w_port_nxt;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_pad
    assign pport[g] = r_dir[g] ? r_port[g] : 1'bz;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= pport;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_pin = r_sync[SYNC_STAGES-1];

`ifdef PARALLEL_PORT_CTRL_IRQ_EN
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] r_prev;
  logic             r_irq;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_edge_clr;
  logic             w_wr_mask;
  logic             w_wr_edge;

  assign w_wr_mask  = w_wr && (avs_address == A_MASK);
  assign w_wr_edge  = w_wr && (avs_address == A_EDGE);
  assign w_rise     = w_pin & ~r_prev & ~r_dir;
  assign w_edge_clr = w_wr_edge ? w_bits : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= '0;
      r_mask <= '0;
      r_edge <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_prev <= w_pin;
      if (w_wr_mask) begin
        r_mask <= (r_mask & ~w_be) | (w_wdata & w_be);
      end
      // a fresh edge overrides a same-cycle clear
      r_edge <= (r_edge & ~w_edge_clr) | w_rise;
      r_irq  <= |(r_edge & r_mask);
    end
  end

  assign irq      = r_irq;
  assign w_mask32 = 32'(r_mask);
  assign w_edge32 = 32'(r_edge);
`else
  assign irq      = 1'b0;
  assign w_mask32 = '0;
  assign w_edge32 = '0;
`endif

  always_comb begin
    w_rdata = '0;
    case (avs_address)
      A_DIR:   w_rdata = 32'(r_dir);
      A_PIN:   w_rdata = 32'(w_pin);
      A_PORT:  w_rdata = 32'(r_port);
      A_MASK:  w_rdata = w_mask32;
      A_EDGE:  w_rdata = w_edge32;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else if (w_rd) begin
      r_readdata <= w_rdata;
    end
  end

  assign avs_readdata = r_readdata;

endmodule
